// File: rtl/cpu_core.sv
// cpu_core: multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK core with handshaked data memory.
// Define CPU_MUL_EN to enable the MUL opcode; otherwise 0x09 executes as NOP.
module cpu_core #(
    parameter int DATA_W  = 32,
    parameter int IADDR_W = 12,
    parameter int DADDR_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IADDR_W-1:0] instructionAddress,
    input  logic [31:0]        instructionIn,
    output logic [DADDR_W-1:0] dataAddress,
    output logic [DATA_W-1:0]  dataOut,
    input  logic [DATA_W-1:0]  dataIn,
    output logic               dataReq,
    output logic               dataWrEn,
    input  logic               dataAck,
    output logic [7:0]         cpuStatus
);
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT} state_t;
    state_t state, state_nx;
    logic [IADDR_W-1:0] pc;
    logic [DATA_W-1:0]  regs [16];
    logic [DATA_W-1:0]  a, b, res, alu, ra_val, rb_val, imm;
    logic [DATA_W:0]    add_s, adc_s, sub_s;
    logic [4:0]         opc;
    logic [3:0]         rc;
    logic [2:0]         cond;
    logic cmp, fz, fc, fge, nc, nge, wr, upd, alu_c, is_alu, cond_ok;
`ifdef CPU_MUL_EN
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   res_hi;
    logic                wr_hi;
    assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif
    // regs[15] is the overflow register; regs[14] is shadowed by pc
    assign instructionAddress = pc;
    assign dataReq   = state == MEM;
    assign dataWrEn  = dataReq && opc == 5'h02;
    assign cpuStatus = rst ? 8'h02 : state == HALT ? 8'h04 : 8'h01;
    assign ra_val = instructionIn[30:27] == 4'd14 ? DATA_W'(pc) : regs[instructionIn[30:27]];
    assign rb_val = instructionIn[26:23] >= 4'd14 ? '0 : regs[instructionIn[26:23]];
    assign imm    = DATA_W'($signed(instructionIn[26:13]));
    assign add_s  = {1'b0, a} + {1'b0, b};
    assign adc_s  = add_s + {{DATA_W{1'b0}}, fc};
    assign sub_s  = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
    assign cond_ok = cond == 3'd1 ? 1'b0 : cond == 3'd2 ? fz : cond == 3'd3 ? !fz :
                     cond == 3'd4 ? fge : cond == 3'd5 ? !fge : 1'b1;

    always_comb begin
        alu    = '0;
        alu_c  = 1'b0;
        is_alu = 1'b1;
        case (opc)
            5'h03:   alu = a & b;
            5'h04:   alu = a | b;
            5'h05:   alu = a ^ b;
            5'h06:   {alu_c, alu} = add_s;
            5'h07:   {alu_c, alu} = adc_s;
            5'h08:   {alu_c, alu} = sub_s;
`ifdef CPU_MUL_EN
            5'h09:   alu = prod[DATA_W-1:0];
`endif
            default: is_alu = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            FETCH:     state_nx = DECODE;
            DECODE:    state_nx = EXECUTE;
            EXECUTE:   state_nx = opc == 5'h1F ? HALT : (opc == 5'h01 || opc == 5'h02) ? MEM : WRITEBACK;
            MEM:       state_nx = dataAck ? WRITEBACK : MEM;
            WRITEBACK: state_nx = FETCH;
            default:   state_nx = HALT;
        endcase
    end

    always_ff @(posedge clk) state <= rst ? FETCH : state_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            fz          <= 1'b0;
            fc          <= 1'b0;
            fge         <= 1'b0;
            dataAddress <= '0;
            dataOut     <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            case (state)
                DECODE: begin
                    opc  <= instructionIn[12:8];
                    rc   <= instructionIn[7:4];
                    cond <= instructionIn[3:1];
                    cmp  <= instructionIn[0];
                    a    <= ra_val;
                    b    <= instructionIn[31] ? imm : rb_val;
                end
                EXECUTE: begin
                    res <= alu;
                    nc  <= alu_c;
                    nge <= $signed(a) >= $signed(b);
                    wr  <= (is_alu && cond_ok) || opc == 5'h01;
                    upd <= cmp && (is_alu || opc == 5'h01);
                    if (opc == 5'h01) dataAddress <= add_s[DADDR_W-1:0];
                    if (opc == 5'h02) dataAddress <= b[DADDR_W-1:0];
                    if (opc == 5'h02) dataOut <= a;
`ifdef CPU_MUL_EN
                    res_hi <= prod[2*DATA_W-1:DATA_W];
                    wr_hi  <= opc == 5'h09 && cond_ok;
`endif
                end
                MEM: if (dataAck) res <= dataIn;
                WRITEBACK: begin
                    if (wr && rc != 4'd14) regs[rc] <= res;
`ifdef CPU_MUL_EN
                    if (wr_hi) regs[15] <= res_hi;
`endif
                    pc <= wr && rc == 4'd14 ? res[IADDR_W-1:0] : pc + IADDR_W'(1);
                    if (upd) begin
                        fz  <= res == '0;
                        fc  <= nc;
                        fge <= nge;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed programs for cpu_core; memory transactions are scored against an expected queue.
module tb_cpu_core;
    typedef struct packed {logic we; logic [13:0] addr; logic [31:0] data;} txn_t;
    localparam logic [31:0] HALT_I = 32'h0000_1F00;

    logic clk = 0;
    logic rst;
    logic [11:0] instructionAddress;
    logic [31:0] instructionIn;
    logic [13:0] dataAddress;
    logic [31:0] dataOut, dataIn;
    logic dataReq, dataWrEn, dataAck;
    logic [7:0] cpuStatus;

    logic [31:0] rom [0:4095];
    logic [31:0] dmem [0:255];
    txn_t exp_q[$];
    int vectors = 0, miscompares = 0;
    int req_cnt = 0, ack_delay = 3, exp_len = 3, hi_cnt = 0;
    logic force_ack = 0, prev_req = 0;
    logic [46:0] snap;

    cpu_core dut (
        .clk(clk), .rst(rst),
        .instructionAddress(instructionAddress), .instructionIn(instructionIn),
        .dataAddress(dataAddress), .dataOut(dataOut), .dataIn(dataIn),
        .dataReq(dataReq), .dataWrEn(dataWrEn), .dataAck(dataAck),
        .cpuStatus(cpuStatus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) instructionIn <= rom[instructionAddress];
    always @(posedge clk) req_cnt <= (dataReq && !dataAck) ? req_cnt + 1 : 0;
    assign dataAck = force_ack || (dataReq && req_cnt == ack_delay - 1);
    assign dataIn  = dmem[dataAddress[7:0]];

    function automatic logic [31:0] mk(input logic imb, input logic [3:0] ra, input logic [13:0] im,
                                       input logic [4:0] op, input logic [3:0] rc, input logic [2:0] cd,
                                       input logic cp);
        return {imb, ra, im, op, rc, cd, cp};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_txn(input logic we, input logic [13:0] addr, input logic [31:0] data);
        exp_q.push_back({we, addr, data});
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = HALT_I;
    endtask

    task automatic run_to_halt(input int budget);
        int n = 0;
        while (cpuStatus != 8'h04 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("halt_reached", cpuStatus, 8'h04);
    endtask

    // Monitor: scores every acked transaction and checks request stability and length.
    always @(negedge clk) begin
        if (dataReq) begin
            if (prev_req) check("req_stable", {dataWrEn, dataAddress, dataOut}, snap);
            snap   <= {dataWrEn, dataAddress, dataOut};
            hi_cnt <= prev_req ? hi_cnt + 1 : 1;
            if (dataAck) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL txn_unexpected: addr 0x%0h we %0b with no expected entry", dataAddress, dataWrEn);
                end else begin
                    check("txn_we", dataWrEn, exp_q[0].we);
                    check("txn_addr", dataAddress, exp_q[0].addr);
                    if (exp_q[0].we) check("txn_data", dataOut, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
            end
        end else if (prev_req && exp_len != 0) begin
            check("req_len", hi_cnt, exp_len);
        end
        prev_req <= dataReq;
    end

    initial begin
        rst = 1;
        dmem[8'h40] = 32'hCAFE_F00D;
        dmem[8'h50] = 32'h0001_0000;
        dmem[8'h51] = 32'h0003_0000;
        clear_rom();
        rom[8'h00] = mk(1, 0, 14'd5, 5'h06, 1, 0, 0);
        rom[8'h01] = mk(1, 1, 14'h3FF9, 5'h06, 2, 0, 0);
        rom[8'h02] = mk(1, 1, 14'h20, 5'h02, 0, 0, 0);
        rom[8'h03] = mk(1, 2, 14'h24, 5'h02, 0, 0, 0);
        rom[8'h04] = mk(1, 0, 14'd3, 5'h06, 3, 0, 0);
        rom[8'h05] = mk(1, 3, 14'd3, 5'h08, 4, 0, 1);
        rom[8'h06] = mk(1, 0, 14'h10, 5'h06, 14, 2, 0);
        rom[8'h10] = mk(1, 4, 14'h28, 5'h02, 0, 0, 0);
        rom[8'h11] = mk(1, 3, 14'd2, 5'h08, 5, 0, 1);
        rom[8'h12] = mk(1, 0, 14'h30, 5'h06, 14, 2, 0);
        rom[8'h13] = mk(1, 5, 14'h2C, 5'h02, 0, 0, 0);
        rom[8'h14] = mk(1, 2, 14'h0FF, 5'h03, 6, 0, 0);
        rom[8'h15] = mk(0, 6, 14'h0400, 5'h04, 7, 0, 0);
        rom[8'h16] = mk(1, 7, 14'h0F0, 5'h05, 8, 0, 0);
        rom[8'h17] = mk(1, 0, 14'd1, 5'h08, 9, 0, 1);
        rom[8'h18] = mk(1, 9, 14'd1, 5'h06, 10, 0, 1);
        rom[8'h19] = mk(1, 1, 14'd5, 5'h07, 11, 0, 0);
        rom[8'h1A] = mk(1, 6, 14'h30, 5'h02, 0, 0, 0);
        rom[8'h1B] = mk(1, 7, 14'h31, 5'h02, 0, 0, 0);
        rom[8'h1C] = mk(1, 8, 14'h32, 5'h02, 0, 0, 0);
        rom[8'h1D] = mk(1, 9, 14'h33, 5'h02, 0, 0, 0);
        rom[8'h1E] = mk(1, 11, 14'h34, 5'h02, 0, 0, 0);
        rom[8'h1F] = mk(1, 0, 14'd7, 5'h06, 12, 4, 0);
        rom[8'h20] = mk(1, 0, 14'd9, 5'h06, 13, 5, 0);
        rom[8'h21] = mk(1, 0, 14'h77, 5'h06, 1, 1, 0);
        rom[8'h22] = mk(1, 12, 14'h35, 5'h02, 0, 0, 0);
        rom[8'h23] = mk(1, 13, 14'h36, 5'h02, 0, 0, 0);
        rom[8'h24] = mk(1, 1, 14'h37, 5'h02, 0, 0, 0);
        rom[8'h25] = mk(1, 0, 14'h40, 5'h01, 12, 1, 0);
        rom[8'h26] = mk(1, 12, 14'h38, 5'h02, 0, 0, 0);
        rom[8'h27] = mk(1, 14, 14'd0, 5'h06, 3, 0, 0);
        rom[8'h28] = mk(1, 3, 14'h39, 5'h02, 0, 0, 0);
        rom[8'h29] = mk(0, 1, 14'h3800, 5'h04, 4, 0, 0);
        rom[8'h2A] = mk(1, 4, 14'h3A, 5'h02, 0, 0, 0);
        expect_txn(1, 14'h20, 32'd5);
        expect_txn(1, 14'h24, 32'hFFFF_FFFE);
        expect_txn(1, 14'h28, 32'd0);
        expect_txn(1, 14'h2C, 32'd1);
        expect_txn(1, 14'h30, 32'hFE);
        expect_txn(1, 14'h31, 32'hFF);
        expect_txn(1, 14'h32, 32'h0F);
        expect_txn(1, 14'h33, 32'hFFFF_FFFF);
        expect_txn(1, 14'h34, 32'hB);
        expect_txn(1, 14'h35, 32'd0);
        expect_txn(1, 14'h36, 32'd9);
        expect_txn(1, 14'h37, 32'd5);
        expect_txn(0, 14'h40, 32'd0);
        expect_txn(1, 14'h38, 32'hCAFE_F00D);
        expect_txn(1, 14'h39, 32'h27);
        expect_txn(1, 14'h3A, 32'd5);
        repeat (2) @(posedge clk);
        #1;
        check("rst_status", cpuStatus, 8'h02);
        check("rst_pc", instructionAddress, 12'h0);
        check("rst_req", dataReq, 1'b0);
        check("rst_wren", dataWrEn, 1'b0);
        check("rst_daddr", dataAddress, 14'h0);
        check("rst_dout", dataOut, 32'h0);
        @(negedge clk) rst = 0;
        #1 check("run_status", cpuStatus, 8'h01);
        repeat (4) @(posedge clk);
        #1 check("pc_after_add1", instructionAddress, 12'h1);
        repeat (4) @(posedge clk);
        #1 check("pc_after_add2", instructionAddress, 12'h2);
        run_to_halt(3000);
        check("halt_pc", instructionAddress, 12'h02B);
        repeat (5) @(posedge clk);
        #1 check("halt_pc_held", instructionAddress, 12'h02B);
        check("halt_req", dataReq, 1'b0);
        check("queue_empty_a", exp_q.size(), 0);

        @(negedge clk) rst = 1;
        clear_rom();
        rom[0] = mk(1, 0, 14'h0FFF, 5'h06, 14, 0, 0);
        rom[12'hFFF] = 32'h0;
        ack_delay = 1;
        exp_len = 1;
        @(posedge clk);
        @(negedge clk) rst = 0;
        repeat (4) @(posedge clk);
        #1 check("pc_jump_top", instructionAddress, 12'hFFF);
        repeat (4) @(posedge clk);
        #1 check("pc_wrap", instructionAddress, 12'h000);

        @(negedge clk) rst = 1;
        clear_rom();
        rom[0] = mk(1, 0, 14'h50, 5'h01, 1, 0, 0);
        rom[1] = mk(1, 0, 14'h51, 5'h01, 2, 0, 0);
        rom[2] = mk(1, 0, 14'h123, 5'h06, 3, 0, 0);
        rom[3] = mk(0, 1, 14'h0800, 5'h09, 3, 0, 0);
        rom[4] = mk(1, 3, 14'h60, 5'h02, 0, 0, 0);
        rom[5] = mk(1, 15, 14'h61, 5'h02, 0, 0, 0);
        expect_txn(0, 14'h50, 32'd0);
        expect_txn(0, 14'h51, 32'd0);
`ifdef CPU_MUL_EN
        expect_txn(1, 14'h60, 32'h0);
        expect_txn(1, 14'h61, 32'h3);
`else
        expect_txn(1, 14'h60, 32'h123);
        expect_txn(1, 14'h61, 32'h0);
`endif
        @(posedge clk);
        @(negedge clk) rst = 0;
        run_to_halt(1000);
        check("queue_empty_c", exp_q.size(), 0);

        @(negedge clk) rst = 1;
        clear_rom();
        rom[0] = mk(1, 0, 14'h40, 5'h01, 1, 0, 0);
        rom[1] = mk(1, 1, 14'h70, 5'h02, 0, 0, 0);
        ack_delay = 20;
        exp_len = 0;
        expect_txn(0, 14'h40, 32'd0);
        expect_txn(1, 14'h70, 32'hCAFE_F00D);
        @(posedge clk);
        @(negedge clk) rst = 0;
        for (int i = 0; i < 10 && !dataReq; i++) @(negedge clk);
        check("load_mem_entry", dataReq, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        check("abort_req", dataReq, 1'b0);
        check("abort_status", cpuStatus, 8'h02);
        check("abort_pc", instructionAddress, 12'h0);
        force_ack = 1;
        @(negedge clk) rst = 0;
        ack_delay = 1;
        #1;
        check("abort_run_status", cpuStatus, 8'h01);
        check("abort_late_ack_req", dataReq, 1'b0);
        @(negedge clk) force_ack = 0;
        run_to_halt(500);
        check("queue_empty_d", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end
endmodule
